// File: rtl/clock_divider_prog.sv
// clock_divider_prog: multi-channel programmable integer clock divider.
// Each channel divides clk by its own ratio, sampled only at period starts,
// so a ratio change never produces a runt pulse. A global sync pulse restarts
// every running channel on the same edge.
// Ports:
//   clk      system clock, all logic on rising edge
//   rst      asynchronous active-low reset
//   en       per-channel enable (level)
//   div      per-channel ratio, channel i at div[i*W +: W]
//   sync     single-cycle global realign pulse
//   clk_out  per-channel divided clock (registered)
//   tick     one-cycle pulse on each clk_out rising edge (registered)
//   active   channel running flag (registered)
module clock_divider_prog #(
  parameter int unsigned CH = 3,
  parameter int unsigned W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   en,
  input  logic [CH*W-1:0] div,
  input  logic            sync,
  output logic [CH-1:0]   clk_out,
  output logic [CH-1:0]   tick,
  output logic [CH-1:0]   active
);

  logic [W-1:0] cnt_q     [CH];
  logic [W-1:0] cnt_d     [CH];
  logic [W-1:0] cur_div_q [CH];
  logic [W-1:0] cur_div_d [CH];
  logic [W-1:0] div_eff   [CH];
  logic [W:0]   half      [CH];
  logic [W:0]   cnt_inc   [CH];
  logic [CH-1:0] period_end;
  logic [CH-1:0] clk_out_d;
  logic [CH-1:0] tick_d;
  logic [CH-1:0] active_d;

  // Next-state logic: idle start, normal count, and period end (natural or sync)
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      cnt_d[i]     = cnt_q[i];
      cur_div_d[i] = cur_div_q[i];
      clk_out_d[i] = 1'b0;
      tick_d[i]    = 1'b0;
      active_d[i]  = active[i];

      // Ratios 0 and 1 saturate to 2 so there is never a bypass path
      div_eff[i]    = (div[i*W +: W] < W'(2)) ? W'(2) : div[i*W +: W];
      // One extra bit keeps ceil(cur_div/2) and cnt+1 exact at the top ratio
      half[i]       = ((W+1)'(cur_div_q[i]) + (W+1)'(1)) >> 1;
      cnt_inc[i]    = (W+1)'(cnt_q[i]) + (W+1)'(1);
      period_end[i] = (cnt_q[i] == cur_div_q[i] - W'(1)) || sync;

      if (!active[i]) begin
        if (en[i]) begin
          active_d[i]  = 1'b1;
          cur_div_d[i] = div_eff[i];
          cnt_d[i]     = '0;
          clk_out_d[i] = 1'b1;
          tick_d[i]    = 1'b1;
        end
      end else if (period_end[i]) begin
        cnt_d[i] = '0;
        if (en[i]) begin
          cur_div_d[i] = div_eff[i];
          clk_out_d[i] = 1'b1;
          tick_d[i]    = 1'b1;
        end else begin
          active_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i]     = W'(cnt_inc[i]);
        clk_out_d[i] = (cnt_inc[i] < half[i]);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        cnt_q[i]     <= '0;
        cur_div_q[i] <= W'(2);
      end
      clk_out <= '0;
      tick    <= '0;
      active  <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        cnt_q[i]     <= cnt_d[i];
        cur_div_q[i] <= cur_div_d[i];
      end
      clk_out <= clk_out_d;
      tick    <= tick_d;
      active  <= active_d;
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
module tb_clock_divider_prog;
  localparam int unsigned CH = 3;
  localparam int unsigned W  = 4;

  logic            clk = 1'b1;
  logic            rst = 1'b0;
  logic [CH-1:0]   en  = '0;
  logic [CH*W-1:0] div = '0;
  logic            sync = 1'b0;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   active;

  int checks   = 0;
  int failures = 0;

  // Rising edges at 20, 40, 60 ns; falling edges at 10, 30, 50 ns
  always #10 clk = ~clk;

  clock_divider_prog #(.CH(CH), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div     (div),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .active  (active)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset, load enables/ratios, release on the next falling edge
  task automatic start(input logic [CH-1:0] e, input logic [CH*W-1:0] d);
    rst  = 1'b0;
    en   = e;
    div  = d;
    sync = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    en  = 3'b111;
    div = {4'd8, 4'd4, 4'd2};
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({clk_out, tick, active} !== 9'b0) begin
        failures++;
        $display("FAIL reset k=%0d got clk=%b tick=%b act=%b exp all 0", k, clk_out, tick, active);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // /2, /4, /8 equivalence with the fixed divider
  task automatic test_regression();
    logic [2:0] ec, et;
    for (int k = 0; k < 16; k++) begin
      step();
      ec = {(k % 8) < 4, (k % 4) < 2, (k % 2) < 1};
      et = {(k % 8) == 0, (k % 4) == 0, (k % 2) == 0};
      checks++;
      if (clk_out !== ec || tick !== et || active !== 3'b111) begin
        failures++;
        $display("FAIL regression k=%0d got clk=%b tick=%b act=%b exp clk=%b tick=%b act=111",
                 k, clk_out, tick, active, ec, et);
      end
    end
  endtask

  // Odd ratio duty and saturation of ratios 0 and 1
  task automatic test_odd_and_saturation();
    logic [2:0] ec, et;
    start(3'b001, {4'd0, 4'd0, 4'd5});
    for (int k = 0; k < 15; k++) begin
      step();
      ec = {2'b00, (k % 5) < 3};
      et = {2'b00, (k % 5) == 0};
      checks++;
      if (clk_out !== ec || tick !== et || active !== 3'b001) begin
        failures++;
        $display("FAIL odd5 k=%0d got clk=%b tick=%b act=%b exp clk=%b tick=%b act=001",
                 k, clk_out, tick, active, ec, et);
      end
    end
    for (int r = 0; r < 2; r++) begin
      start(3'b001, {8'd0, 4'(r)});
      for (int k = 0; k < 6; k++) begin
        step();
        ec = {2'b00, (k % 2) == 0};
        checks++;
        if (clk_out !== ec || tick !== ec || active !== 3'b001) begin
          failures++;
          $display("FAIL sat_div%0d k=%0d got clk=%b tick=%b act=%b exp clk=%b tick=%b act=001",
                   r, k, clk_out, tick, active, ec, ec);
        end
      end
    end
  endtask

  // Ratio 4 -> 6 at cnt=1 takes effect only at the next period start
  task automatic test_ratio_change();
    int ph, r;
    logic [2:0] ec, et;
    start(3'b010, {4'd0, 4'd4, 4'd0});
    for (int k = 0; k < 16; k++) begin
      step();
      if (k < 4) begin ph = k; r = 4; end
      else begin ph = (k - 4) % 6; r = 6; end
      ec = {1'b0, ph < (r + 1) / 2, 1'b0};
      et = {1'b0, ph == 0, 1'b0};
      checks++;
      if (clk_out !== ec || tick !== et || active !== 3'b010) begin
        failures++;
        $display("FAIL ratio_change k=%0d got clk=%b tick=%b act=%b exp clk=%b tick=%b act=010",
                 k, clk_out, tick, active, ec, et);
      end
      if (k == 1) div[7:4] = 4'd6;
    end
  endtask

  // en dropped mid-period finishes the period, then re-enable restarts next edge
  task automatic test_en_drop();
    logic [2:0] ec, et, ea;
    start(3'b100, {4'd8, 4'd0, 4'd0});
    for (int k = 0; k < 11; k++) begin
      step();
      if (k < 8) begin
        ec = {k < 4, 2'b00}; et = {k == 0, 2'b00}; ea = 3'b100;
      end else if (k < 10) begin
        ec = 3'b000; et = 3'b000; ea = 3'b000;
      end else begin
        ec = 3'b100; et = 3'b100; ea = 3'b100;
      end
      checks++;
      if (clk_out !== ec || tick !== et || active !== ea) begin
        failures++;
        $display("FAIL en_drop k=%0d got clk=%b tick=%b act=%b exp clk=%b tick=%b act=%b",
                 k, clk_out, tick, active, ec, et, ea);
      end
      if (k == 2) en = 3'b000;
      if (k == 9) en = 3'b100;
    end
  endtask

  // /4 and /6 out of phase, sync realigns both; idle channel 2 ignores sync
  task automatic test_sync();
    int ph0, ph1;
    logic s;
    logic [2:0] ec, et, ea;
    ph0 = 0;
    ph1 = 0;
    start(3'b001, {4'd0, 4'd6, 4'd4});
    for (int k = 0; k < 15; k++) begin
      step();
      s = (k == 3);
      if (k == 0 || s) ph0 = 0; else ph0 = (ph0 + 1) % 4;
      if (k == 1 || s) ph1 = 0; else if (k > 1) ph1 = (ph1 + 1) % 6;
      ec = {1'b0, (k >= 1) && ph1 < 3, ph0 < 2};
      et = {1'b0, (k >= 1) && ph1 == 0, ph0 == 0};
      ea = {1'b0, k >= 1, 1'b1};
      checks++;
      if (clk_out !== ec || tick !== et || active !== ea) begin
        failures++;
        $display("FAIL sync k=%0d got clk=%b tick=%b act=%b exp clk=%b tick=%b act=%b",
                 k, clk_out, tick, active, ec, et, ea);
      end
      if (k == 0) en = 3'b011;
      sync = (k == 2);
    end
  endtask

  // Async reset between edges clears outputs without a clock edge
  task automatic test_async_reset();
    start(3'b001, {4'd0, 4'd0, 4'd4});
    step();
    checks++;
    if (clk_out !== 3'b001 || tick !== 3'b001 || active !== 3'b001) begin
      failures++;
      $display("FAIL async_pre got clk=%b tick=%b act=%b exp clk=001 tick=001 act=001",
               clk_out, tick, active);
    end
    #4;
    rst = 1'b0;
    #1;
    checks++;
    if ({clk_out, tick, active} !== 9'b0) begin
      failures++;
      $display("FAIL async_clear got clk=%b tick=%b act=%b exp all 0", clk_out, tick, active);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++;
    if (clk_out !== 3'b001 || tick !== 3'b001 || active !== 3'b001) begin
      failures++;
      $display("FAIL async_restart got clk=%b tick=%b act=%b exp clk=001 tick=001 act=001",
               clk_out, tick, active);
    end
  endtask

  initial begin
    test_reset();
    test_regression();
    test_odd_and_saturation();
    test_ratio_change();
    test_en_drop();
    test_sync();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Multi-channel programmable clock divider; parametrised successor to the fixed /2, /4, /8 divider.
- Each of CH channels divides `clk` by an independently programmable integer ratio.
- Per channel outputs: a registered divided clock, a one-cycle tick at each divided rising edge, and an active flag.
- Supports glitch-free ratio changes at period boundaries, per-channel enable/disable at period boundaries, and a global phase-realign pulse.
- Outputs are single-edge registered (posedge clk only). They feed clock-enable logic and low-speed fabric, never clock muxes.

Parameters:
- CH, 3, number of independent divider channels (1..16).
- W, 8, width of each channel's divide ratio; maximum ratio is 2^W-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous active-low reset; 0 resets all state immediately, release is synchronous to clk.
- en  input  CH  per-channel enable, level-sensitive.
- div  input  CH*W  per-channel ratio; channel i uses div[i*W +: W]; sampled only at period start.
- sync  input  1  single-cycle global realign pulse.
- clk_out  output  CH  per-channel divided clock, registered.
- tick  output  CH  one-clk pulse coincident with each clk_out rising edge.
- active  output  CH  1 while the channel is running.

Behaviour:
- Reset (rst=0, async): clk_out=0, tick=0, active=0; per channel cnt=0 and cur_div=2.
- Ratio saturation: eff(div) = 2 if div<2, else div. Ratios 0 and 1 never produce bypass or combinational clock paths.
- Per-channel state: cnt (W bits), cur_div (W bits), active. H = ceil(cur_div/2) = (cur_div+1)>>1.
- IDLE (active=0):
  - On an edge with en=1: active<=1, cur_div<=eff(div), cnt<=0, clk_out<=1, tick<=1.
  - Latency is one clk from en sampled high to clk_out high.
  - Otherwise all outputs stay 0.
- RUN (active=1), normal step (cnt != cur_div-1 and no sync):
  - cnt<=cnt+1, clk_out<=(cnt+1 < H), tick<=0.
- RUN, period end (cnt == cur_div-1, or sync=1):
  - If en=1: restart the period. cnt<=0, cur_div<=eff(div), clk_out<=1, tick<=1.
  - If en=0: stop. active<=0, clk_out<=0, tick<=0, cnt<=0.
- Waveform per period: clk_out is high H cycles and low cur_div-H cycles.
  - Even ratios give 50% duty.
  - Odd ratios are high one cycle longer than low.
  - Period is exactly cur_div clks.
- Ratio changes mid-period are ignored until the next period start, so there are no runt pulses.
- Deassertion of en mid-period completes the current period, then the channel stops. Re-assertion before the period end means no stop occurs.
- sync:
  - Forces a period end on every running channel this edge (truncated period allowed; this is the only permitted short pulse).
  - On an IDLE channel, sync has no effect beyond the normal en rule. An idle channel with en=1 and sync=1 starts normally.
  - Simultaneous sync and natural period end behave identically to a single period end.
- Channels are fully independent apart from the shared sync.
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset asserted mid-operation clears everything asynchronously.
- After reset release, a channel with en=1 starts on the first clk edge.

Test Plan:
- CH=3, W=4, div={8,4,2}, en=3'b111 after rst release at 50ns, clk period 20ns: clk_out[0..2] toggle at /2, /4, /8 with 50% duty. First tick on all three on the first edge after release; ticks every 2, 4, 8 clks. This is regression equivalence with the fixed divider.
- div[0]=5: clk_out[0] repeats high 3, low 2; tick every 5 clks. div[0]=0 and div[0]=1 each behave as /2.
- div[1] changed 4->6 at cnt=1: the current period finishes at 4 clks, then periods of 6 (high 3/low 3). No pulse shorter than 2 clks.
- en[2] dropped at cnt=2 of a /8 period: clk_out[2] completes 8 clks, then active[2]=0 and clk_out[2]=0. Re-raising en[2] gives clk_out high and tick on the next edge.
- Channels running /4 and /6 out of phase, one-cycle sync pulse: next edge tick=1 and clk_out=1 on both channels; thereafter aligned with cnt=0 together.
- rst pulled low mid-high-phase between clk edges: clk_out, tick, active go 0 immediately without waiting for clk. After release with en=1, restart on the first edge.
